pipeline_hazard_controller: RTL and testbench

//  Sequences the 5-stage MIPS pipeline: drives the PC/nPC/IF-ID load enables, the
//  CU NOP-mux select and the PC target-select (S). Sits between Control_Unit,

---
 rtl/pipeline_hazard_controller_pkg.sv | 20 ++
 rtl/pipeline_hazard_controller_forward_select.sv | 28 ++
 rtl/pipeline_hazard_controller.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// rtl/pipeline_hazard_controller_pkg.sv - shared state and forwarding encodings for the hazard controller
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LWAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // A stage can supply an operand only if it really writes a non-zero register.
  function automatic logic stage_match(input logic en, input logic [4:0] rd, input logic [4:0] src);
    return en && (rd != 5'd0) && (rd == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_forward_select.sv
// rtl/pipeline_hazard_controller_forward_select.sv - operand source select, EX > MEM > WB > RF
module pipeline_hazard_controller_forward_select
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] ex_rd,
  input  logic       ex_rf_enable,
  input  logic       ex_load_instr,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_enable,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_enable,
  output logic [1:0] sel
);

  // Load data is not ready in EX; the bubble logic covers that case.
  always_comb begin
    sel = FWD_RF;
    if (stage_match(ex_rf_enable && !ex_load_instr, ex_rd, src)) begin
      sel = FWD_EX;
    end else if (stage_match(mem_rf_enable, mem_rd, src)) begin
      sel = FWD_MEM;
    end else if (stage_match(wb_rf_enable, wb_rd, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - fetch hold, load-use bubbles, branch select and forwarding for a 5-stage MIPS pipe
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_ub_instr,
  input  logic             id_cond_taken,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load_instr,
  input  logic             ex_rf_enable,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rf_enable,
  input  logic [4:0]       wb_rd,
  input  logic             wb_rf_enable,
  output logic             pc_ld,
  output logic             npc_ld,
  output logic             ifid_ld,
  output logic             nop_sel,
  output logic             S,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  localparam int HW = (RESET_HOLD_CYCLES > 2) ? $clog2(RESET_HOLD_CYCLES) : 1;

  state_t        state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [3:0]    wait_cnt, wait_n;
  logic          loads, bubble, hazard;
  logic [1:0]    fwd_a_raw, fwd_b_raw;

  assign hazard = ex_load_instr && ex_rf_enable && (ex_rd != 5'd0) &&
                  ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_HOLD;
      hold_cnt    <= HW'(RESET_HOLD_CYCLES - 1);
      wait_cnt    <= 4'd0;
      stall_count <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      wait_cnt <= wait_n;
      if (bubble && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    wait_n  = wait_cnt;
    loads   = 1'b0;
    nop_sel = 1'b1;
    S       = 1'b0;
    bubble  = 1'b0;
    case (state)
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          state_n = ST_RUN;
        end else begin
          hold_n = hold_cnt - 1'b1;
        end
      end
      ST_RUN: begin
        if (hazard) begin
          bubble = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_n = ST_LWAIT;
            wait_n  = 4'(LOAD_STALL_CYCLES - 2);
          end
        end else begin
          loads   = 1'b1;
          nop_sel = 1'b0;
          S       = id_ub_instr || id_cond_taken;
        end
      end
      ST_LWAIT: begin
        bubble = 1'b1;
        if (wait_cnt == 4'd0) begin
          state_n = ST_RUN;
        end else begin
          wait_n = wait_cnt - 1'b1;
        end
      end
      default: state_n = ST_HOLD;
    endcase
    // Reset forces a safe pipeline regardless of the registered state.
    if (Reset) begin
      loads   = 1'b0;
      nop_sel = 1'b1;
      S       = 1'b0;
      bubble  = 1'b0;
    end
  end

  assign pc_ld   = loads;
  assign npc_ld  = loads;
  assign ifid_ld = loads;

  pipeline_hazard_controller_forward_select u_fwd_rs (
    .src           (id_rs),
    .ex_rd         (ex_rd),
    .ex_rf_enable  (ex_rf_enable),
    .ex_load_instr (ex_load_instr),
    .mem_rd        (mem_rd),
    .mem_rf_enable (mem_rf_enable),
    .wb_rd         (wb_rd),
    .wb_rf_enable  (wb_rf_enable),
    .sel           (fwd_a_raw)
  );

  pipeline_hazard_controller_forward_select u_fwd_rt (
    .src           (id_rt),
    .ex_rd         (ex_rd),
    .ex_rf_enable  (ex_rf_enable),
    .ex_load_instr (ex_load_instr),
    .mem_rd        (mem_rd),
    .mem_rf_enable (mem_rf_enable),
    .wb_rd         (wb_rd),
    .wb_rf_enable  (wb_rf_enable),
    .sel           (fwd_b_raw)
  );

  assign fwd_a = Reset ? FWD_RF : fwd_a_raw;
  assign fwd_b = Reset ? FWD_RF : fwd_b_raw;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller (1- and 3-bubble variants)
module tb_pipeline_hazard_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
  logic       id_uses_rt = 0, id_ub_instr = 0, id_cond_taken = 0;
  logic       ex_load_instr = 0, ex_rf_enable = 0, mem_rf_enable = 0, wb_rf_enable = 0;

  logic        pc1, npc1, ifid1, nop1, s1, pc3, npc3, ifid3, nop3, s3;
  logic [1:0]  fa1, fb1, fa3, fb3;
  logic [15:0] cnt1, cnt3;

  typedef struct packed {
    logic ld1, nop1, s1, ld3, nop3, s3;
    logic [1:0] fa, fb;
    logic [15:0] c1, c3;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  always #5 Clk = ~Clk;

  pipeline_hazard_controller dut1 (
    .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ub_instr(id_ub_instr), .id_cond_taken(id_cond_taken), .ex_rd(ex_rd),
    .ex_load_instr(ex_load_instr), .ex_rf_enable(ex_rf_enable), .mem_rd(mem_rd),
    .mem_rf_enable(mem_rf_enable), .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
    .pc_ld(pc1), .npc_ld(npc1), .ifid_ld(ifid1), .nop_sel(nop1), .S(s1),
    .fwd_a(fa1), .fwd_b(fb1), .stall_count(cnt1)
  );

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ub_instr(id_ub_instr), .id_cond_taken(id_cond_taken), .ex_rd(ex_rd),
    .ex_load_instr(ex_load_instr), .ex_rf_enable(ex_rf_enable), .mem_rd(mem_rd),
    .mem_rf_enable(mem_rf_enable), .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
    .pc_ld(pc3), .npc_ld(npc3), .ifid_ld(ifid3), .nop_sel(nop3), .S(s3),
    .fwd_a(fa3), .fwd_b(fb3), .stall_count(cnt3)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check({n, ".loads1"}, {29'd0, pc1, npc1, ifid1}, {29'd0, {3{e.ld1}}});
      check({n, ".nop1"},   {31'd0, nop1}, {31'd0, e.nop1});
      check({n, ".S1"},     {31'd0, s1},   {31'd0, e.s1});
      check({n, ".loads3"}, {29'd0, pc3, npc3, ifid3}, {29'd0, {3{e.ld3}}});
      check({n, ".nop3"},   {31'd0, nop3}, {31'd0, e.nop3});
      check({n, ".S3"},     {31'd0, s3},   {31'd0, e.s3});
      check({n, ".fwd_a"},  {28'd0, fa1, fa3}, {28'd0, e.fa, e.fa});
      check({n, ".fwd_b"},  {28'd0, fb1, fb3}, {28'd0, e.fb, e.fb});
      check({n, ".cnt1"},   {16'd0, cnt1}, {16'd0, e.c1});
      check({n, ".cnt3"},   {16'd0, cnt3}, {16'd0, e.c3});
    end
  end

  task automatic next();
    @(posedge Clk);
    #1;
    Reset = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_ub_instr = 0; id_cond_taken = 0;
    ex_rd = 0; ex_load_instr = 0; ex_rf_enable = 0; mem_rd = 0; mem_rf_enable = 0;
    wb_rd = 0; wb_rf_enable = 0;
  endtask

  task automatic haz8();
    ex_load_instr = 1; ex_rf_enable = 1; ex_rd = 8; id_rs = 8;
  endtask

  task automatic expect_out(input string nm, input logic l1, n1, sa, l3, n3, sb,
                            input logic [1:0] fa, fb, input logic [15:0] c1, c3);
    exp_t e;
    e = '{ld1: l1, nop1: n1, s1: sa, ld3: l3, nop3: n3, s3: sb, fa: fa, fb: fb, c1: c1, c3: c3};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge Clk);
    next(); Reset = 1; id_rs = 5; ex_rd = 5; ex_rf_enable = 1;
    expect_out("in_reset", 0,1,0, 0,1,0, 2'b00, 2'b00, 0, 0);
    next(); id_rs = 5; ex_rd = 5; ex_rf_enable = 1; id_cond_taken = 1;
    expect_out("hold1", 0,1,0, 0,1,0, 2'b01, 2'b00, 0, 0);
    next();
    expect_out("hold2", 0,1,0, 0,1,0, 2'b00, 2'b00, 0, 0);
    next();
    expect_out("run", 1,0,0, 1,0,0, 2'b00, 2'b00, 0, 0);

    next(); haz8();
    expect_out("lu_rs", 0,1,0, 0,1,0, 2'b00, 2'b00, 0, 0);
    next(); id_rs = 8; mem_rd = 8; mem_rf_enable = 1;
    expect_out("lu_rs_rel", 1,0,0, 0,1,0, 2'b10, 2'b00, 1, 1);
    next();
    expect_out("lu_rs_w", 1,0,0, 0,1,0, 2'b00, 2'b00, 1, 2);
    next();
    expect_out("lu_rs_done", 1,0,0, 1,0,0, 2'b00, 2'b00, 1, 3);

    next(); ex_load_instr = 1; ex_rf_enable = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 1; id_rs = 3;
    expect_out("lu_rt", 0,1,0, 0,1,0, 2'b00, 2'b00, 1, 3);
    next(); id_rt = 9; id_uses_rt = 1;
    expect_out("lu_rt_b2", 1,0,0, 0,1,0, 2'b00, 2'b00, 2, 4);
    next(); id_rt = 9; id_uses_rt = 1;
    expect_out("lu_rt_b3", 1,0,0, 0,1,0, 2'b00, 2'b00, 2, 5);
    next();
    expect_out("lu_rt_done", 1,0,0, 1,0,0, 2'b00, 2'b00, 2, 6);
    next(); ex_load_instr = 1; ex_rf_enable = 1; ex_rd = 9; id_rt = 9;
    expect_out("rt_unused", 1,0,0, 1,0,0, 2'b00, 2'b00, 2, 6);

    next(); ex_rd = 5; ex_rf_enable = 1; mem_rd = 5; mem_rf_enable = 1; id_rs = 5; id_rt = 5;
    expect_out("fwd_ex", 1,0,0, 1,0,0, 2'b01, 2'b01, 2, 6);
    next(); ex_rd = 5; mem_rd = 5; mem_rf_enable = 1; id_rs = 5; id_rt = 5;
    expect_out("fwd_mem", 1,0,0, 1,0,0, 2'b10, 2'b10, 2, 6);
    next(); ex_rf_enable = 1; mem_rf_enable = 1; wb_rf_enable = 1;
    expect_out("fwd_r0", 1,0,0, 1,0,0, 2'b00, 2'b00, 2, 6);
    next(); wb_rd = 7; wb_rf_enable = 1; id_rs = 7; id_rt = 2;
    expect_out("fwd_wb", 1,0,0, 1,0,0, 2'b11, 2'b00, 2, 6);
    next(); ex_load_instr = 1; ex_rf_enable = 1; ex_rd = 7; mem_rd = 7; mem_rf_enable = 1;
    wb_rd = 7; wb_rf_enable = 1; id_rs = 4; id_rt = 7;
    expect_out("fwd_ld_skip", 1,0,0, 1,0,0, 2'b00, 2'b10, 2, 6);

    next(); id_cond_taken = 1;
    expect_out("br_cond", 1,0,1, 1,0,1, 2'b00, 2'b00, 2, 6);
    next(); id_ub_instr = 1;
    expect_out("br_ub", 1,0,1, 1,0,1, 2'b00, 2'b00, 2, 6);
    next(); id_cond_taken = 1; haz8();
    expect_out("br_haz", 0,1,0, 0,1,0, 2'b00, 2'b00, 2, 6);
    next(); id_cond_taken = 1;
    expect_out("br_rel", 1,0,1, 0,1,0, 2'b00, 2'b00, 3, 7);
    next(); id_cond_taken = 1;
    expect_out("br_w", 1,0,1, 0,1,0, 2'b00, 2'b00, 3, 8);
    next(); id_cond_taken = 1;
    expect_out("br_rel3", 1,0,1, 1,0,1, 2'b00, 2'b00, 3, 9);

    next(); haz8();
    expect_out("pre_rst", 0,1,0, 0,1,0, 2'b00, 2'b00, 3, 9);
    next(); haz8(); Reset = 1;
    expect_out("rst_lwait", 0,1,0, 0,1,0, 2'b00, 2'b00, 4, 10);
    next();
    expect_out("rst_hold1", 0,1,0, 0,1,0, 2'b00, 2'b00, 0, 0);
    next();
    expect_out("rst_hold2", 0,1,0, 0,1,0, 2'b00, 2'b00, 0, 0);
    next();
    expect_out("rst_run", 1,0,0, 1,0,0, 2'b00, 2'b00, 0, 0);

    for (int i = 0; i < 65540; i++) begin
      next(); haz8();
    end
    next(); haz8();
    expect_out("sat1", 0,1,0, 0,1,0, 2'b00, 2'b00, 16'hFFFF, 16'hFFFF);
    next(); haz8();
    expect_out("sat2", 0,1,0, 0,1,0, 2'b00, 2'b00, 16'hFFFF, 16'hFFFF);

    next();
    repeat (2) @(posedge Clk);
    check("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
